cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with per-FU result slots (optional CDB_PERF_EN counters)
module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int TAG_W  = 3,
  parameter int XLEN   = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*XLEN-1:0]   fu_value,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]          cdb_value
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]              perf_bcast_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] r_full;
  logic [TAG_W-1:0]  r_tag   [NUM_FU];
  logic [XLEN-1:0]   r_value [NUM_FU];
  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [XLEN-1:0]   r_cdb_value;

  logic [NUM_FU-1:0] w_grant;
  logic              w_grant_any;
  logic [PTR_W-1:0]  w_grant_idx;
  logic [PTR_W:0]    w_scan_sum;
  logic [PTR_W-1:0]  w_scan_idx;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [NUM_FU-1:0] w_accept;

  // A slot takes a new result when empty or when it is draining onto the CDB this cycle
  assign fu_ready = {NUM_FU{reset_n && !flush}} & (~r_full | w_grant);
  assign w_accept = fu_valid & fu_ready;

  // Round-robin scan from r_rr_ptr; wrap is an explicit compare so non-power-of-2 NUM_FU works
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan_sum  = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_scan_sum > (PTR_W+1)'(NUM_FU-1)) begin
        w_scan_sum = w_scan_sum - (PTR_W+1)'(NUM_FU);
      end
      w_scan_idx = w_scan_sum[PTR_W-1:0];
      if (!w_grant_any && r_full[w_scan_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan_idx;
      end
    end
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
    end
  end

  assign w_next_ptr = (w_grant_idx == PTR_W'(NUM_FU-1)) ? '0 : w_grant_idx + 1'b1;

  // Slot occupancy, pointer and broadcast register; flush squashes like reset
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_full      <= '0;
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_accept[i]) begin
          r_full[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
      if (w_grant_any) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= r_tag[w_grant_idx];
        r_cdb_value <= r_value[w_grant_idx];
        r_rr_ptr    <= w_next_ptr;
      end else begin
        // Invalid CDB must carry tag 0 since consumers compare tags unconditionally
        r_cdb_valid <= 1'b0;
        r_cdb_tag   <= '0;
        r_cdb_value <= '0;
      end
    end
  end

  // Slot payload capture; contents are only meaningful while the full bit is set
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_accept[i]) begin
        r_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
        r_value[i] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_value = r_cdb_value;

`ifdef CDB_PERF_EN
  logic [31:0] r_perf_bcast_cnt;
  logic [31:0] r_perf_stall_cnt;
  logic        w_stall;

  assign w_stall = (|(fu_valid & ~fu_ready)) && reset_n && !flush;

  // Broadcast and back-pressure counters survive flush, clear only on reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_perf_bcast_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (w_grant_any && !flush) begin
        r_perf_bcast_cnt <= r_perf_bcast_cnt + 32'd1;
      end
      if (w_stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_bcast_cnt = r_perf_bcast_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

  // Tag 0 is the reserved no-tag value and must never be presented as a result
  always @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (reset_n && fu_valid[i]) begin
        assert (fu_tag[i*TAG_W +: TAG_W] != '0);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int NUM_FU = 5;
  localparam int TAG_W  = 3;
  localparam int XLEN   = 32;

  logic                    clock;
  logic                    reset_n;
  logic                    flush;
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
`ifdef CDB_PERF_EN
  logic [31:0]             perf_bcast_cnt;
  logic [31:0]             perf_stall_cnt;
`endif

  int n_cmp;
  int n_err;

  cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value)
`ifdef CDB_PERF_EN
    ,
    .perf_bcast_cnt (perf_bcast_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] val);
    fu_valid[i] = v;
    fu_tag[i*TAG_W +: TAG_W] = t;
    fu_value[i*XLEN +: XLEN] = val;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_cdb(input string name, input logic v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] val);
    chk({name, ".valid"}, 64'(cdb_valid), 64'(v));
    chk({name, ".tag"},   64'(cdb_tag),   64'(t));
    chk({name, ".value"}, 64'(cdb_value), 64'(val));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;

    // Reset held with every FU presenting a result
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, TAG_W'(i+1), 32'hA000 + i);
    step();
    chk("rst0.ready", 64'(fu_ready), 64'h0);
    chk_cdb("rst0", 1'b0, 3'd0, 32'h0);
    step();
    chk("rst1.ready", 64'(fu_ready), 64'h0);
    chk_cdb("rst1", 1'b0, 3'd0, 32'h0);
    fu_valid = '0;
    reset_n  = 1'b1;
    settle();
    chk("rel.ready", 64'(fu_ready), 64'h1f);
    step();
    chk_cdb("rel0", 1'b0, 3'd0, 32'h0);
    step();
    chk_cdb("rel1", 1'b0, 3'd0, 32'h0);

    // Single result from FU0: two-cycle latency, then back to tag 0
    set_fu(0, 1'b1, 3'd3, 32'hDEADBEEF);
    step();
    chk_cdb("single.E", 1'b0, 3'd0, 32'h0);
    chk("single.ready_on_grant", 64'(fu_ready), 64'h1f);
    fu_valid = '0;
    step();
    chk_cdb("single.E1", 1'b1, 3'd3, 32'hDEADBEEF);
    step();
    chk_cdb("single.E2", 1'b0, 3'd0, 32'h0);

    // Flush with nothing buffered returns the pointer to slot 0
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_cdb("ptr_flush", 1'b0, 3'd0, 32'h0);

    // Round-robin across all five slots, slot 0 refilled while it drains
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, TAG_W'(i+1), 32'h100 + i);
    step();
    fu_valid = '0;
    set_fu(0, 1'b1, 3'd6, 32'h66);
    settle();
    chk("rr.ready_grant0", 64'(fu_ready), 64'h01);
    step();
    fu_valid = '0;
    chk_cdb("rr.t1", 1'b1, 3'd1, 32'h100);
    step();
    chk_cdb("rr.t2", 1'b1, 3'd2, 32'h101);
    step();
    chk_cdb("rr.t3", 1'b1, 3'd3, 32'h102);
    step();
    chk_cdb("rr.t4", 1'b1, 3'd4, 32'h103);
    step();
    chk_cdb("rr.t5", 1'b1, 3'd5, 32'h104);
    step();
    chk_cdb("rr.t6", 1'b1, 3'd6, 32'h66);
    step();
    chk_cdb("rr.idle", 1'b0, 3'd0, 32'h0);

    // FU2 streams three results back to back
    set_fu(2, 1'b1, 3'd1, 32'h201);
    settle();
    chk("b2b.ready0", 64'(fu_ready[2]), 64'h1);
    step();
    set_fu(2, 1'b1, 3'd2, 32'h202);
    settle();
    chk("b2b.ready1", 64'(fu_ready[2]), 64'h1);
    step();
    chk_cdb("b2b.t1", 1'b1, 3'd1, 32'h201);
    set_fu(2, 1'b1, 3'd3, 32'h203);
    settle();
    chk("b2b.ready2", 64'(fu_ready[2]), 64'h1);
    step();
    chk_cdb("b2b.t2", 1'b1, 3'd2, 32'h202);
    fu_valid = '0;
    step();
    chk_cdb("b2b.t3", 1'b1, 3'd3, 32'h203);
    step();
    chk_cdb("b2b.idle", 1'b0, 3'd0, 32'h0);

    // Flush drops buffered slots 1 and 3 and resets the pointer
    set_fu(1, 1'b1, 3'd4, 32'h401);
    set_fu(3, 1'b1, 3'd5, 32'h503);
    step();
    fu_valid = '0;
    flush    = 1'b1;
    settle();
    chk("fl.ready_during", 64'(fu_ready), 64'h0);
    step();
    flush = 1'b0;
    chk_cdb("fl.E1", 1'b0, 3'd0, 32'h0);
    settle();
    chk("fl.ready_after", 64'(fu_ready), 64'h1f);
    step();
    chk_cdb("fl.E2", 1'b0, 3'd0, 32'h0);
    // Pointer at 0 means FU0 wins over FU4 (a stale pointer of 3 would pick FU4)
    set_fu(0, 1'b1, 3'd1, 32'h10);
    set_fu(4, 1'b1, 3'd2, 32'h14);
    step();
    fu_valid = '0;
    step();
    chk_cdb("fl.ptr0", 1'b1, 3'd1, 32'h10);
    step();
    chk_cdb("fl.ptr1", 1'b1, 3'd2, 32'h14);
    step();
    chk_cdb("fl.idle", 1'b0, 3'd0, 32'h0);

    // Mid-operation reset discards buffered results
    set_fu(2, 1'b1, 3'd7, 32'h77);
    step();
    fu_valid = '0;
    reset_n  = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk_cdb("midrst", 1'b0, 3'd0, 32'h0);

`ifdef CDB_PERF_EN
    // Counters: five results, then FU4 waits four cycles for its slot
    settle();
    chk("perf.bcast0", 64'(perf_bcast_cnt), 64'd0);
    chk("perf.stall0", 64'(perf_stall_cnt), 64'd0);
    for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, TAG_W'(i+1), 32'h300 + i);
    step();
    fu_valid = '0;
    set_fu(4, 1'b1, 3'd6, 32'h306);
    step();
    step();
    step();
    step();
    chk("perf.ready4", 64'(fu_ready[4]), 64'h1);
    step();
    fu_valid = '0;
    step();
    chk_cdb("perf.t6", 1'b1, 3'd6, 32'h306);
    step();
    chk("perf.bcast", 64'(perf_bcast_cnt), 64'd6);
    chk("perf.stall", 64'(perf_stall_cnt), 64'd4);
    set_fu(0, 1'b1, 3'd1, 32'h1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    fu_valid = '0;
    step();
    chk("perf.bcast_fl", 64'(perf_bcast_cnt), 64'd6);
    chk("perf.stall_fl", 64'(perf_stall_cnt), 64'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
